// File: rtl/udp_scb_pkg.sv
// Shared types and helpers for the sequential UDP flip-flop scoreboard.
package udp_scb_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StDrive,
    StEdge,
    StCheck,
    StDone
  } state_e;

  localparam int unsigned STEP_CYCLES = 3;

  // Next q of the dual-edge cell: rising edge loads d, falling edge loads ~d.
  function automatic logic next_q(input logic edge_rising, input logic d);
    return edge_rising ? d : ~d;
  endfunction

endpackage

// File: rtl/udp_ff_model.sv
// One-bit reference model of the dual-edge UDP flip-flop, advanced one edge per load.
module udp_ff_model
  import udp_scb_pkg::*;
#(
  parameter logic INIT_Q = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic init,
  input  logic load,
  input  logic edge_rising,
  input  logic d,
  output logic q
);

  logic q_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q <= INIT_Q;
    end else if (init) begin
      q_q <= INIT_Q;
    end else if (load) begin
      q_q <= next_q(edge_rising, d);
    end
  end

  assign q = q_q;

endmodule

// File: rtl/udp_ff_scoreboard.sv
// Drives a dual-edge UDP flip-flop through a fixed data pattern and checks its output
// against a reference model, reporting a verdict and a saturating mismatch count.
module udp_ff_scoreboard
  import udp_scb_pkg::*;
#(
  parameter int unsigned           NUM_STEPS = 16,
  parameter logic [NUM_STEPS-1:0]  PATTERN   = 16'hA5C3,
  parameter logic                  INIT_Q    = 1'b1,
  parameter int unsigned           ERRW      = 8,
  localparam int unsigned          SW        = $clog2(NUM_STEPS) + 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  output logic            cell_clk,
  output logic            cell_d,
  input  logic            cell_q,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [ERRW-1:0] err_count,
  output logic [SW-1:0]   step_idx
);

  state_e          state_q, state_d;
  logic            cell_clk_q, cell_clk_d;
  logic            cell_d_q, cell_d_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            pass_q, pass_d;
  logic [ERRW-1:0] err_q, err_d;
  logic [SW-1:0]   step_q, step_d;

  logic            model_init;
  logic            model_load;
  logic            exp_q;
  logic [ERRW-1:0] err_next;

  udp_ff_model #(
    .INIT_Q (INIT_Q)
  ) u_model (
    .clk         (clk),
    .rst_n       (rst_n),
    .init        (model_init),
    .load        (model_load),
    .edge_rising (~cell_clk_q),
    .d           (cell_d_q),
    .q           (exp_q)
  );

  always_comb begin
    state_d    = state_q;
    cell_clk_d = cell_clk_q;
    cell_d_d   = cell_d_q;
    busy_d     = busy_q;
    done_d     = done_q;
    pass_d     = pass_q;
    err_d      = err_q;
    step_d     = step_q;
    model_init = 1'b0;
    model_load = 1'b0;
    err_next   = err_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d    = StDrive;
          err_d      = '0;
          step_d     = '0;
          pass_d     = 1'b0;
          busy_d     = 1'b1;
          model_init = 1'b1;
        end
      end
      StDrive: begin
        cell_d_d = PATTERN[step_q[SW-2:0]];
        state_d  = StEdge;
      end
      StEdge: begin
        // The model sees the post-toggle level, so ~cell_clk_q marks a rising edge.
        cell_clk_d = ~cell_clk_q;
        model_load = 1'b1;
        state_d    = StCheck;
      end
      StCheck: begin
        // X/Z on the cell output is a mismatch too.
        if ((cell_q !== exp_q) && (err_q != '1)) begin
          err_next = err_q + ERRW'(1);
        end
        err_d = err_next;
        if (step_q == SW'(NUM_STEPS - 1)) begin
          state_d = StDone;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          pass_d  = (err_next == '0);
        end else begin
          step_d  = step_q + SW'(1);
          state_d = StDrive;
        end
      end
      StDone: begin
        done_d  = 1'b0;
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      cell_clk_q <= 1'b0;
      cell_d_q   <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      err_q      <= '0;
      step_q     <= '0;
    end else begin
      state_q    <= state_d;
      cell_clk_q <= cell_clk_d;
      cell_d_q   <= cell_d_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      pass_q     <= pass_d;
      err_q      <= err_d;
      step_q     <= step_d;
    end
  end

  assign cell_clk  = cell_clk_q;
  assign cell_d    = cell_d_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign err_count = err_q;
  assign step_idx  = step_q;

endmodule

// File: tb/tb_udp_ff_scoreboard.sv
// Bench for udp_ff_scoreboard: a behavioural dual-edge cell feeds the DUT, and a
// cycle-count model predicts every output on every cycle.
module tb_udp_ff_scoreboard;
  import udp_scb_pkg::*;

  localparam int          NS  = 16;
  localparam logic [15:0] PAT = 16'hA5C3;
  localparam int          RUN = STEP_CYCLES * NS + 1;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       start2 = 1'b0;
  logic       cell_clk, cell_d, cell_q, busy, done, pass;
  logic [7:0] err_count;
  logic [4:0] step_idx;
  logic       cell_clk2, cell_d2, busy2, done2, pass2;
  logic [1:0] err2;
  logic [4:0] step2;

  always #5 clk = ~clk;

  udp_ff_scoreboard dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .cell_clk  (cell_clk),
    .cell_d    (cell_d),
    .cell_q    (cell_q),
    .busy      (busy),
    .done      (done),
    .pass      (pass),
    .err_count (err_count),
    .step_idx  (step_idx)
  );

  udp_ff_scoreboard #(
    .ERRW (2)
  ) dut2 (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start2),
    .cell_clk  (cell_clk2),
    .cell_d    (cell_d2),
    .cell_q    (1'b0),
    .busy      (busy2),
    .done      (done2),
    .pass      (pass2),
    .err_count (err2),
    .step_idx  (step2)
  );

  // Golden dual-edge cell: rising loads d, falling loads ~d, powers up at 1.
  logic good_q = 1'b1;
  always @(posedge cell_clk or negedge cell_clk) good_q <= cell_clk ? cell_d : ~cell_d;

  // 0: correct cell, 1: tied 0, 2: tied 1, 3: correct cell but unknown value in step 3
  int   mode = 0;
  logic x_bit;
  assign x_bit = 1'bx;
  always @* begin
    case (mode)
      1: cell_q = 1'b0;
      2: cell_q = 1'b1;
      3: begin
        if (busy && step_idx == 5'd3) begin
          // Two-state simulators resolve X to a level; use a known-wrong value then.
          cell_q = (x_bit === 1'b0 || x_bit === 1'b1) ? ~good_q : x_bit;
        end else begin
          cell_q = good_q;
        end
      end
      default: cell_q = good_q;
    endcase
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: k = cycles since the accepted start (0 = idle).
  logic [15:0] pat = PAT;
  int   k = 0;
  int   run_mode = 0;
  logic m_clk = 1'b0, m_d = 1'b0, m_pass = 1'b0;
  int   m_step = 0, m_err = 0;
  int   toggles = 0;
  logic prev_clk = 1'b0;

  function automatic logic exp_bit(input int i);
    return (i % 2 == 0) ? pat[i] : ~pat[i];
  endfunction

  function automatic logic mism(input int i, input int md);
    case (md)
      1:       return exp_bit(i) == 1'b1;
      2:       return exp_bit(i) == 1'b0;
      3:       return i == 3;
      default: return 1'b0;
    endcase
  endfunction

  task automatic model_reset();
    k = 0; m_clk = 0; m_d = 0; m_pass = 0; m_step = 0; m_err = 0;
  endtask

  task automatic compare_all();
    check("busy", 32'(busy), 32'(k >= 1 && k < RUN));
    check("done", 32'(done), 32'(k == RUN));
    check("cell_clk", 32'(cell_clk), 32'(m_clk));
    check("cell_d", 32'(cell_d), 32'(m_d));
    check("step_idx", 32'(step_idx), 32'(m_step));
    check("err_count", 32'(err_count), 32'(m_err));
    check("pass", 32'(pass), 32'(m_pass));
  endtask

  task automatic tick();
    logic s;
    logic r;
    int   nck;
    int   cnt;
    s = start;
    @(posedge clk);
    r = rst_n;
    #1;
    if (!r) begin
      model_reset();
    end else begin
      if (k == 0) begin
        if (s) begin
          k = 1;
          run_mode = mode;
        end
      end else if (k == RUN) begin
        k = 0;
      end else begin
        k++;
      end
      if (k > 0) begin
        m_clk  = ((k / 3) % 2) == 1;
        m_step = (k - 1) / 3;
        if (m_step > NS - 1) m_step = NS - 1;
        if (k >= 2) m_d = pat[(k - 2) / 3];
        nck = (k - 1) / 3;
        if (nck > NS) nck = NS;
        cnt = 0;
        for (int i = 0; i < nck; i++) if (mism(i, run_mode)) cnt++;
        m_err  = (cnt > 255) ? 255 : cnt;
        m_pass = (k == RUN) ? (m_err == 0) : 1'b0;
      end
    end
    if (cell_clk !== prev_clk) toggles++;
    prev_clk = cell_clk;
    compare_all();
  endtask

  // Runs one sequence; start is re-pulsed on cycles re1/re2 of the run (0 = never).
  task automatic run(input int md, input int re1, input int re2, output int done_at,
                     output int done_cnt);
    int c;
    mode = md;
    toggles = 0;
    done_cnt = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    c = 1;
    done_at = 0;
    while (c < 60) begin
      start = (c == re1 || c == re2);
      tick();
      c++;
      if (done === 1'b1) begin
        done_cnt++;
        if (done_at == 0) done_at = c;
      end
    end
    start = 1'b0;
    if (done_at == 0) check("done_timeout", 32'(0), 32'(1));
  endtask

  initial begin
    int    done_at;
    int    done_cnt;
    int    c;
    logic [15:0] seq;

    #1;
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_done", 32'(done), 32'(0));
    check("rst_pass", 32'(pass), 32'(0));
    check("rst_err", 32'(err_count), 32'(0));
    check("rst_step", 32'(step_idx), 32'(0));
    check("rst_cell_clk", 32'(cell_clk), 32'(0));
    check("rst_cell_d", 32'(cell_d), 32'(0));
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < NS; i++) seq[i] = exp_bit(i);
    check("model_seq", 32'(seq), 32'h0F69);

    // Correct cell: clean run.
    run(0, 0, 0, done_at, done_cnt);
    check("t1_done_at", 32'(done_at), 32'(49));
    check("t1_toggles", 32'(toggles), 32'(16));
    check("t1_clk_end", 32'(cell_clk), 32'(0));
    check("t1_err", 32'(err_count), 32'(0));
    check("t1_pass", 32'(pass), 32'(1));

    // Tied 0, with the 2-bit counter instance alongside.
    start2 = 1'b1;
    fork
      run(1, 0, 0, done_at, done_cnt);
      begin
        @(posedge clk);
        #1 start2 = 1'b0;
      end
    join
    check("t2_err0", 32'(err_count), 32'(8));
    check("t2_pass0", 32'(pass), 32'(0));
    check("t3_err_sat", 32'(err2), 32'(3));
    check("t3_pass", 32'(pass2), 32'(0));

    run(2, 0, 0, done_at, done_cnt);
    check("t2_err1", 32'(err_count), 32'(8));
    check("t2_pass1", 32'(pass), 32'(0));

    // Start re-pulsed mid-run is ignored.
    run(1, 5, 20, done_at, done_cnt);
    check("t4_done_at", 32'(done_at), 32'(49));
    check("t4_done_cnt", 32'(done_cnt), 32'(1));
    mode = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("t4_err_clear", 32'(err_count), 32'(0));
    c = 0;
    while (done !== 1'b1 && c < 100) begin
      tick();
      c++;
    end
    check("t4_rerun_pass", 32'(pass), 32'(1));
    tick();

    // Asynchronous reset at step 5 after its falling edge.
    mode = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    c = 0;
    while (k != 18 && c < 100) begin
      tick();
      c++;
    end
    check("t5_step", 32'(step_idx), 32'(5));
    check("t5_clk_low", 32'(cell_clk), 32'(0));
    #2 rst_n = 1'b0;
    #1;
    check("t5_busy", 32'(busy), 32'(0));
    check("t5_err", 32'(err_count), 32'(0));
    check("t5_step_rst", 32'(step_idx), 32'(0));
    check("t5_cell_d", 32'(cell_d), 32'(0));
    check("t5_pass", 32'(pass), 32'(0));
    model_reset();
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    run(0, 0, 0, done_at, done_cnt);
    check("t5_done_at", 32'(done_at), 32'(49));
    check("t5_err_after", 32'(err_count), 32'(0));
    check("t5_pass_after", 32'(pass), 32'(1));

    // Unknown cell output during step 3 only.
    run(3, 0, 0, done_at, done_cnt);
    check("t6_err", 32'(err_count), 32'(1));
    check("t6_pass", 32'(pass), 32'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
